vc_address_tracker: RTL and testbench

//  Multi-virtual-channel generalisation of the single-channel flit address counter.

---
 rtl/vc_address_tracker.sv | 107 ++++++++++
 tb/tb_vc_address_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_address_tracker.sv
// Per-virtual-channel packet boundary tracker: latches head length/address per VC and counts body flits down.
// Optional feature: define VC_TRACKER_STATS_EN to add per-VC completed-packet counters (pkt_count_o).
module vc_address_tracker #(
    parameter int NUM_VC     = 2,
    parameter int LEN_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8,
    localparam int VC_W      = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pop_valid,
    input  logic [VC_W-1:0]                pop_vc,
    input  logic                           pop_head,
    input  logic [LEN_WIDTH-1:0]           pop_len,
    input  logic [ADDR_WIDTH-1:0]          pop_addr,
    output logic [ADDR_WIDTH-1:0]          flit_addr_o,
    output logic [NUM_VC-1:0]              vc_busy_o,
    output logic [NUM_VC*ADDR_WIDTH-1:0]   vc_addr_o,
    output logic [NUM_VC*LEN_WIDTH-1:0]    vc_remain_o,
`ifdef VC_TRACKER_STATS_EN
    output logic [NUM_VC*16-1:0]           pkt_count_o,
`endif
    output logic [2:0]                     err_o
);

    localparam logic [VC_W:0] NUM_VC_L = NUM_VC[VC_W:0];

    // Packed per-VC state so the flattened outputs carry VC0 in the LSBs.
    logic [NUM_VC-1:0][LEN_WIDTH-1:0]  remain_q, remain_d;
    logic [NUM_VC-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                        err_q, err_d;
    logic                              vc_ok;
`ifdef VC_TRACKER_STATS_EN
    logic [NUM_VC-1:0][15:0]           count_q, count_d;
`endif

    always_comb begin
        vc_ok       = ({1'b0, pop_vc} < NUM_VC_L);
        remain_d    = remain_q;
        addr_d      = addr_q;
        err_d       = '0;
        flit_addr_o = '0;
`ifdef VC_TRACKER_STATS_EN
        count_d     = count_q;
`endif
        if (pop_valid) begin
            if (!vc_ok) begin
                err_d[2] = 1'b1;
            end else begin
                // Only the addressed VC is touched; all others hold.
                for (int v = 0; v < NUM_VC; v++) begin
                    if (pop_vc == VC_W'(v)) begin
                        if (pop_head) begin
                            flit_addr_o = pop_addr;
                            if (remain_q[v] != '0) err_d[0] = 1'b1;
                            remain_d[v] = pop_len;
                            addr_d[v]   = pop_addr;
`ifdef VC_TRACKER_STATS_EN
                            if (pop_len == '0) count_d[v] = count_q[v] + 16'd1;
`endif
                        end else if (remain_q[v] != '0) begin
                            flit_addr_o = addr_q[v];
                            remain_d[v] = remain_q[v] - LEN_WIDTH'(1);
`ifdef VC_TRACKER_STATS_EN
                            if (remain_q[v] == LEN_WIDTH'(1)) count_d[v] = count_q[v] + 16'd1;
`endif
                        end else begin
                            err_d[1] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= '0;
            addr_q   <= '0;
            err_q    <= '0;
`ifdef VC_TRACKER_STATS_EN
            count_q  <= '0;
`endif
        end else begin
            remain_q <= remain_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
`ifdef VC_TRACKER_STATS_EN
            count_q  <= count_d;
`endif
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_busy_o[v] = (remain_q[v] != '0);
        end
    end

    assign vc_addr_o   = addr_q;
    assign vc_remain_o = remain_q;
    assign err_o       = err_q;
`ifdef VC_TRACKER_STATS_EN
    assign pkt_count_o = count_q;
`endif

endmodule

// File: tb/tb_vc_address_tracker.sv
// Directed bench for vc_address_tracker: NUM_VC=2 main instance plus NUM_VC=3 and NUM_VC=1 instances.
module tb_vc_address_tracker;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared payload, per-instance valid and VC select.
    logic       pop_head;
    logic [7:0] pop_len;
    logic [7:0] pop_addr;
    logic       v2, v3, v1;
    logic       vc2;
    logic [1:0] vc3;
    logic       vc1;

    logic [7:0]  fa2, fa3, fa1;
    logic [1:0]  busy2;
    logic [2:0]  busy3;
    logic [0:0]  busy1;
    logic [15:0] addr2, rem2;
    logic [23:0] addr3, rem3;
    logic [7:0]  addr1, rem1;
    logic [2:0]  err2, err3, err1;
`ifdef VC_TRACKER_STATS_EN
    logic [31:0] cnt2;
    logic [47:0] cnt3;
    logic [15:0] cnt1;
`endif

    vc_address_tracker #(.NUM_VC(2)) dut (
        .clk(clk), .rst(rst), .pop_valid(v2), .pop_vc(vc2), .pop_head(pop_head),
        .pop_len(pop_len), .pop_addr(pop_addr), .flit_addr_o(fa2), .vc_busy_o(busy2),
        .vc_addr_o(addr2), .vc_remain_o(rem2),
`ifdef VC_TRACKER_STATS_EN
        .pkt_count_o(cnt2),
`endif
        .err_o(err2));

    vc_address_tracker #(.NUM_VC(3)) dut3 (
        .clk(clk), .rst(rst), .pop_valid(v3), .pop_vc(vc3), .pop_head(pop_head),
        .pop_len(pop_len), .pop_addr(pop_addr), .flit_addr_o(fa3), .vc_busy_o(busy3),
        .vc_addr_o(addr3), .vc_remain_o(rem3),
`ifdef VC_TRACKER_STATS_EN
        .pkt_count_o(cnt3),
`endif
        .err_o(err3));

    vc_address_tracker #(.NUM_VC(1)) dut1 (
        .clk(clk), .rst(rst), .pop_valid(v1), .pop_vc(vc1), .pop_head(pop_head),
        .pop_len(pop_len), .pop_addr(pop_addr), .flit_addr_o(fa1), .vc_busy_o(busy1),
        .vc_addr_o(addr1), .vc_remain_o(rem1),
`ifdef VC_TRACKER_STATS_EN
        .pkt_count_o(cnt1),
`endif
        .err_o(err1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one pop on instance inst (2, 3 or 1), check the combinational address, then clock it in.
    task automatic pop(input int inst, input logic head, input int vc, input int len,
                       input int addr, input logic [7:0] exp_flit, input string tag);
        v2 = (inst == 2); v3 = (inst == 3); v1 = (inst == 1);
        vc2 = vc[0]; vc3 = vc[1:0]; vc1 = vc[0];
        pop_head = head; pop_len = len[7:0]; pop_addr = addr[7:0];
        #1;
        case (inst)
            2: check(tag, {24'd0, fa2}, {24'd0, exp_flit});
            3: check(tag, {24'd0, fa3}, {24'd0, exp_flit});
            default: check(tag, {24'd0, fa1}, {24'd0, exp_flit});
        endcase
        @(posedge clk); #1;
        v2 = 1'b0; v3 = 1'b0; v1 = 1'b0;
    endtask

    task automatic idle();
        v2 = 1'b0; v3 = 1'b0; v1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; v2 = 0; v3 = 0; v1 = 0; vc2 = 0; vc3 = 0; vc1 = 0;
        pop_head = 0; pop_len = 0; pop_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_remain", {16'd0, rem2}, 32'h0);
        check("rst_addr", {16'd0, addr2}, 32'h0);
        check("rst_busy", {30'd0, busy2}, 32'h0);
        check("rst_err", {29'd0, err2}, 32'h0);
        rst = 1'b0;

        // 1: single packet of 3 body flits on vc0
        pop(2, 1, 0, 3, 'h5A, 8'h5A, "t1_head_flit");
        check("t1_rem3", {16'd0, rem2}, 32'h0003);
        check("t1_busy", {30'd0, busy2}, 32'h1);
        check("t1_addr", {16'd0, addr2}, 32'h005A);
        pop(2, 0, 0, 0, 0, 8'h5A, "t1_body1_flit");
        check("t1_rem2", {16'd0, rem2}, 32'h0002);
        pop(2, 0, 0, 0, 0, 8'h5A, "t1_body2_flit");
        check("t1_rem1", {16'd0, rem2}, 32'h0001);
        check("t1_busy_mid", {30'd0, busy2}, 32'h1);
        pop(2, 0, 0, 0, 0, 8'h5A, "t1_body3_flit");
        check("t1_rem0", {16'd0, rem2}, 32'h0000);
        check("t1_busy_end", {30'd0, busy2}, 32'h0);
        check("t1_err", {29'd0, err2}, 32'h0);

        // 2: interleaved packets on vc0 and vc1
        pop(2, 1, 0, 2, 'h11, 8'h11, "t2_head0_flit");
        pop(2, 1, 1, 1, 'h22, 8'h22, "t2_head1_flit");
        check("t2_rem_both", {16'd0, rem2}, 32'h0102);
        check("t2_addr_both", {16'd0, addr2}, 32'h2211);
        check("t2_busy_both", {30'd0, busy2}, 32'h3);
        pop(2, 0, 1, 0, 0, 8'h22, "t2_body1_flit");
        check("t2_rem_a", {16'd0, rem2}, 32'h0002);
        check("t2_busy_a", {30'd0, busy2}, 32'h1);
        pop(2, 0, 0, 0, 0, 8'h11, "t2_body0a_flit");
        pop(2, 0, 0, 0, 0, 8'h11, "t2_body0b_flit");
        check("t2_rem_end", {16'd0, rem2}, 32'h0000);
        check("t2_busy_end", {30'd0, busy2}, 32'h0);

        // 3: single-flit packet, then body on idle VC
        pop(2, 1, 1, 0, 'h33, 8'h33, "t3_head_flit");
        check("t3_busy", {30'd0, busy2}, 32'h0);
        check("t3_addr", {16'd0, addr2}, 32'h3311);
        check("t3_err_none", {29'd0, err2}, 32'h0);
        pop(2, 0, 1, 0, 0, 8'h00, "t3_body_idle_flit");
        check("t3_err_body_idle", {29'd0, err2}, 32'h2);
        check("t3_rem_hold", {16'd0, rem2}, 32'h0000);
        idle();
        check("t3_err_one_cycle", {29'd0, err2}, 32'h0);
`ifdef VC_TRACKER_STATS_EN
        check("t3_pkt_count", cnt2, 32'h0002_0002);
`endif

        // 4: head mid-packet aborts and reloads
        pop(2, 1, 0, 4, 'h40, 8'h40, "t4_head_flit");
        check("t4_rem4", {16'd0, rem2}, 32'h0004);
        pop(2, 0, 0, 0, 0, 8'h40, "t4_body_flit");
        check("t4_rem3", {16'd0, rem2}, 32'h0003);
        pop(2, 1, 0, 1, 'h44, 8'h44, "t4_rehead_flit");
        check("t4_err_head_mid", {29'd0, err2}, 32'h1);
        check("t4_rem_reload", {16'd0, rem2}, 32'h0001);
        check("t4_addr_reload", {16'd0, addr2}, 32'h3344);
`ifdef VC_TRACKER_STATS_EN
        check("t4_pkt_abort", cnt2, 32'h0002_0002);
`endif
        pop(2, 0, 0, 0, 0, 8'h44, "t4_last_flit");
        check("t4_rem_end", {16'd0, rem2}, 32'h0000);
        check("t4_err_clear", {29'd0, err2}, 32'h0);
`ifdef VC_TRACKER_STATS_EN
        check("t4_pkt_done", cnt2, 32'h0002_0003);
`endif

        // no pop: address output is 0 even with head asserted
        pop_head = 1; pop_addr = 8'hEE; v2 = 0;
        #1;
        check("nopop_flit", {24'd0, fa2}, 32'h0);

        // 5: maximum length, then reset with a concurrent offending pop
        pop(2, 1, 0, 255, 'h77, 8'h77, "t5_head_flit");
        check("t5_rem_max", {16'd0, rem2}, 32'h00FF);
        check("t5_busy", {30'd0, busy2}, 32'h1);
        rst = 1'b1;
        pop(2, 1, 0, 9, 'h88, 8'h88, "t5_rst_pop_flit");
        rst = 1'b0;
        check("t5_rst_remain", {16'd0, rem2}, 32'h0);
        check("t5_rst_addr", {16'd0, addr2}, 32'h0);
        check("t5_rst_busy", {30'd0, busy2}, 32'h0);
        check("t5_rst_err", {29'd0, err2}, 32'h0);

        // 6a: NUM_VC=3, out-of-range VC index
        pop(3, 1, 3, 5, 'h99, 8'h00, "t6_badvc_flit");
        check("t6_err_badvc", {29'd0, err3}, 32'h4);
        check("t6_rem_untouched", {8'd0, rem3}, 32'h0);
        check("t6_addr_untouched", {8'd0, addr3}, 32'h0);
        pop(3, 1, 2, 1, 'hAB, 8'hAB, "t6_head2_flit");
        check("t6_err_ok", {29'd0, err3}, 32'h0);
        check("t6_rem_vc2", {8'd0, rem3}, 32'h010000);
        check("t6_busy_vc2", {29'd0, busy3}, 32'h4);
        pop(3, 0, 3, 0, 0, 8'h00, "t6_badbody_flit");
        check("t6_err_badbody", {29'd0, err3}, 32'h4);
        check("t6_rem_hold", {8'd0, rem3}, 32'h010000);
        pop(3, 0, 2, 0, 0, 8'hAB, "t6_body2_flit");
        check("t6_rem_end", {8'd0, rem3}, 32'h0);

        // 6b: NUM_VC=1 packet and an out-of-range VC
        pop(1, 1, 0, 2, 'h5A, 8'h5A, "t6_n1_head_flit");
        check("t6_n1_rem2", {24'd0, rem1}, 32'h02);
        check("t6_n1_busy", {31'd0, busy1}, 32'h1);
        pop(1, 0, 1, 0, 0, 8'h00, "t6_n1_badvc_flit");
        check("t6_n1_err_badvc", {29'd0, err1}, 32'h4);
        check("t6_n1_rem_hold", {24'd0, rem1}, 32'h02);
        pop(1, 0, 0, 0, 0, 8'h5A, "t6_n1_body1_flit");
        check("t6_n1_rem1", {24'd0, rem1}, 32'h01);
        pop(1, 0, 0, 0, 0, 8'h5A, "t6_n1_body2_flit");
        check("t6_n1_rem0", {24'd0, rem1}, 32'h00);
        check("t6_n1_busy_end", {31'd0, busy1}, 32'h0);
        check("t6_n1_addr", {24'd0, addr1}, 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
